alu_issue_stage: RTL and testbench

Issue stage directly upstream of the 32-bit ALU (`alu_32bit`). It accepts decoded MIPS instructions with register operands, and resolves a single writeback forwarding path. It selects the ALU operation code and B operand, and buffers up to two ready-to-execute operations in a FIFO with a valid/ready handshake. Its outputs `out_a`, `out_b` and `out_oper` drive the ALU's `a`, `b` and `oper` inputs directly.

---
 rtl/alu_issue_stage.sv | 179 +++++++++++++++++
 tb/tb_alu_issue_stage.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// Issue stage feeding alu_32bit: decodes MIPS ALU instructions, resolves one writeback
// forwarding path at acceptance, and buffers up to two operations in a valid/ready FIFO.
module alu_issue_stage #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  in_opcode,
    input  logic [5:0]  in_funct,
    input  logic [15:0] in_imm,
    input  logic [4:0]  in_rs_idx,
    input  logic [4:0]  in_rt_idx,
    input  logic [31:0] in_rs_val,
    input  logic [31:0] in_rt_val,
    input  logic        fwd_valid,
    input  logic [4:0]  fwd_idx,
    input  logic [31:0] fwd_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    output logic [2:0]  out_oper,
    output logic        out_illegal,
    output logic [15:0] issue_count
);

    localparam logic [2:0] OpAnd = 3'b000;
    localparam logic [2:0] OpOr  = 3'b001;
    localparam logic [2:0] OpAdd = 3'b010;
    localparam logic [2:0] OpSub = 3'b110;
    localparam logic [2:0] OpSlt = 3'b111;
    localparam logic [2:0] OpSll = 3'b101;

    logic [31:0] a_q    [DEPTH];
    logic [31:0] b_q    [DEPTH];
    logic [2:0]  oper_q [DEPTH];
    logic        ill_q  [DEPTH];

    logic [1:0]  count_q, count_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        ready_q, ready_d;
    logic [15:0] issue_count_q, issue_count_d;

    logic        push, pop;
    logic [31:0] rs_eff, rt_eff;
    logic [31:0] dec_a, dec_b;
    logic [2:0]  dec_oper;
    logic        dec_ill;

    // Forwarding and decode of the instruction currently offered upstream.
    always_comb begin
        rs_eff = in_rs_val;
        rt_eff = in_rt_val;
        if (fwd_valid && (fwd_idx == in_rs_idx) && (in_rs_idx != 5'd0)) rs_eff = fwd_data;
        if (fwd_valid && (fwd_idx == in_rt_idx) && (in_rt_idx != 5'd0)) rt_eff = fwd_data;

        dec_oper = OpAnd;
        dec_a    = 32'd0;
        dec_b    = 32'd0;
        dec_ill  = 1'b1;
        case (in_opcode)
            6'b000000: begin
                case (in_funct)
                    6'b100100: begin dec_oper = OpAnd; dec_ill = 1'b0; end
                    6'b100101: begin dec_oper = OpOr;  dec_ill = 1'b0; end
                    6'b100000: begin dec_oper = OpAdd; dec_ill = 1'b0; end
                    6'b100010: begin dec_oper = OpSub; dec_ill = 1'b0; end
                    6'b101010: begin dec_oper = OpSlt; dec_ill = 1'b0; end
                    default: ;
                endcase
                if (!dec_ill) begin
                    dec_a = rs_eff;
                    dec_b = rt_eff;
                end
                // The ALU only shifts by one, so any other shamt is undecodable.
                if ((in_funct == 6'b000000) && (in_imm[10:6] == 5'd1)) begin
                    dec_oper = OpSll;
                    dec_a    = rt_eff;
                    dec_b    = 32'd0;
                    dec_ill  = 1'b0;
                end
            end
            6'b001000: begin
                dec_oper = OpAdd;
                dec_a    = rs_eff;
                dec_b    = {{16{in_imm[15]}}, in_imm};
                dec_ill  = 1'b0;
            end
            6'b001010: begin
                dec_oper = OpSlt;
                dec_a    = rs_eff;
                dec_b    = {{16{in_imm[15]}}, in_imm};
                dec_ill  = 1'b0;
            end
            6'b001100: begin
                dec_oper = OpAnd;
                dec_a    = rs_eff;
                dec_b    = {16'd0, in_imm};
                dec_ill  = 1'b0;
            end
            6'b001101: begin
                dec_oper = OpOr;
                dec_a    = rs_eff;
                dec_b    = {16'd0, in_imm};
                dec_ill  = 1'b0;
            end
            default: ;
        endcase
    end

    assign push = in_valid && ready_q && !flush;
    assign pop  = out_valid && out_ready && !flush;

    always_comb begin
        count_d       = count_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        issue_count_d = issue_count_q;
        if (flush) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = ~wr_ptr_q;
            if (pop) begin
                rd_ptr_d      = ~rd_ptr_q;
                issue_count_d = issue_count_q + 16'd1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
        // Registered so that in_ready has no path from out_ready and stays low in reset.
        ready_d = (count_d != 2'd2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q       <= 2'd0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            ready_q       <= 1'b0;
            issue_count_q <= 16'd0;
            for (int i = 0; i < DEPTH; i++) begin
                a_q[i]    <= 32'd0;
                b_q[i]    <= 32'd0;
                oper_q[i] <= 3'd0;
                ill_q[i]  <= 1'b0;
            end
        end else begin
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            ready_q       <= ready_d;
            issue_count_q <= issue_count_d;
            if (push) begin
                a_q[wr_ptr_q]    <= dec_a;
                b_q[wr_ptr_q]    <= dec_b;
                oper_q[wr_ptr_q] <= dec_oper;
                ill_q[wr_ptr_q]  <= dec_ill;
            end
        end
    end

    assign in_ready    = ready_q;
    assign out_valid   = (count_q != 2'd0);
    assign out_a       = a_q[rd_ptr_q];
    assign out_b       = b_q[rd_ptr_q];
    assign out_oper    = oper_q[rd_ptr_q];
    assign out_illegal = ill_q[rd_ptr_q];
    assign issue_count = issue_count_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with hand-computed expected values.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_opcode;
    logic [5:0]  in_funct;
    logic [15:0] in_imm;
    logic [4:0]  in_rs_idx, in_rt_idx;
    logic [31:0] in_rs_val, in_rt_val;
    logic        fwd_valid;
    logic [4:0]  fwd_idx;
    logic [31:0] fwd_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a, out_b;
    logic [2:0]  out_oper;
    logic        out_illegal;
    logic [15:0] issue_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_issue_stage #(.DEPTH(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_opcode   (in_opcode),
        .in_funct    (in_funct),
        .in_imm      (in_imm),
        .in_rs_idx   (in_rs_idx),
        .in_rt_idx   (in_rt_idx),
        .in_rs_val   (in_rs_val),
        .in_rt_val   (in_rt_val),
        .fwd_valid   (fwd_valid),
        .fwd_idx     (fwd_idx),
        .fwd_data    (fwd_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_a       (out_a),
        .out_b       (out_b),
        .out_oper    (out_oper),
        .out_illegal (out_illegal),
        .issue_count (issue_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [5:0] op, input logic [5:0] fn, input logic [15:0] imm,
                         input logic [4:0] rs, input logic [31:0] rsv,
                         input logic [4:0] rt, input logic [31:0] rtv);
        in_valid  = 1'b1;
        in_opcode = op;
        in_funct  = fn;
        in_imm    = imm;
        in_rs_idx = rs;
        in_rs_val = rsv;
        in_rt_idx = rt;
        in_rt_val = rtv;
    endtask

    task automatic check_head(input string tag, input logic [2:0] oper, input logic [31:0] a,
                              input logic [31:0] b, input logic ill);
        check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, ".oper"}, {29'd0, out_oper}, {29'd0, oper});
        check({tag, ".a"}, out_a, a);
        check({tag, ".b"}, out_b, b);
        check({tag, ".ill"}, {31'd0, out_illegal}, {31'd0, ill});
    endtask

    initial begin
        int steps;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_opcode = '0; in_funct = '0; in_imm = '0;
        in_rs_idx = '0; in_rt_idx = '0; in_rs_val = '0; in_rt_val = '0;
        fwd_valid = 1'b0; fwd_idx = '0; fwd_data = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst.out_valid", {31'd0, out_valid}, 32'd0);
        check("rst.in_ready", {31'd0, in_ready}, 32'd0);
        check("rst.out_a", out_a, 32'd0);
        check("rst.out_b", out_b, 32'd0);
        check("rst.oper", {29'd0, out_oper}, 32'd0);
        check("rst.ill", {31'd0, out_illegal}, 32'd0);
        check("rst.issue_count", {16'd0, issue_count}, 32'd0);
        #2 rst_n = 1'b1;
        step();
        check("post_rst.in_ready", {31'd0, in_ready}, 32'd1);

        // ADD with one-cycle latency
        out_ready = 1'b1;
        offer(6'b000000, 6'b100000, 16'd0, 5'd5, 32'h3, 5'd6, 32'h4);
        step();
        in_valid = 1'b0;
        check_head("add", 3'b010, 32'h3, 32'h4, 1'b0);
        check("add.cnt_before", {16'd0, issue_count}, 32'd0);
        step();
        check("add.issue_count", {16'd0, issue_count}, 32'd1);
        check("add.drained", {31'd0, out_valid}, 32'd0);

        // ADDI sign-extends, ORI zero-extends
        offer(6'b001000, 6'b000000, 16'hFFFE, 5'd1, 32'h10, 5'd2, 32'h0);
        step();
        check_head("addi", 3'b010, 32'h10, 32'hFFFF_FFFE, 1'b0);
        offer(6'b001101, 6'b000000, 16'hFFFE, 5'd1, 32'h10, 5'd2, 32'h0);
        step();
        in_valid = 1'b0;
        check_head("ori", 3'b001, 32'h10, 32'h0000_FFFE, 1'b0);
        step();
        check("ori.issue_count", {16'd0, issue_count}, 32'd3);

        // Forwarding, including no forwarding into r0
        fwd_valid = 1'b1; fwd_idx = 5'd5; fwd_data = 32'hDEAD_BEEF;
        offer(6'b000000, 6'b100010, 16'd0, 5'd5, 32'h1, 5'd0, 32'h7);
        step();
        check_head("fwd_sub", 3'b110, 32'hDEAD_BEEF, 32'h7, 1'b0);
        fwd_idx = 5'd0;
        offer(6'b000000, 6'b100010, 16'd0, 5'd0, 32'h9, 5'd0, 32'h7);
        step();
        in_valid = 1'b0; fwd_valid = 1'b0;
        check_head("fwd_r0", 3'b110, 32'h9, 32'h7, 1'b0);
        step();
        check("fwd.issue_count", {16'd0, issue_count}, 32'd5);

        // Backpressure: third push refused, fields stable while stalled
        out_ready = 1'b0;
        offer(6'b000000, 6'b100000, 16'd0, 5'd1, 32'h1, 5'd2, 32'h2);
        step();
        check("bp.ready1", {31'd0, in_ready}, 32'd1);
        offer(6'b000000, 6'b100101, 16'd0, 5'd1, 32'h3, 5'd2, 32'h4);
        step();
        check("bp.full_ready", {31'd0, in_ready}, 32'd0);
        offer(6'b000000, 6'b100100, 16'd0, 5'd1, 32'h5, 5'd2, 32'h6);
        step();
        check_head("bp.stall1", 3'b010, 32'h1, 32'h2, 1'b0);
        step();
        check_head("bp.stall2", 3'b010, 32'h1, 32'h2, 1'b0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        check("bp.no_same_cycle_ready", {31'd0, in_ready}, 32'd0);
        step();
        check_head("bp.second", 3'b001, 32'h3, 32'h4, 1'b0);
        check("bp.ready_after_pop", {31'd0, in_ready}, 32'd1);
        step();
        check("bp.drained", {31'd0, out_valid}, 32'd0);
        check("bp.issue_count", {16'd0, issue_count}, 32'd7);

        // Illegal encodings keep order, then a legal SLL-by-1
        offer(6'b000000, 6'b000000, 16'h0080, 5'd0, 32'h0, 5'd3, 32'h5);
        step();
        check_head("sll2", 3'b000, 32'h0, 32'h0, 1'b1);
        offer(6'b111111, 6'b100000, 16'h1234, 5'd1, 32'h11, 5'd2, 32'h22);
        step();
        check_head("op3f", 3'b000, 32'h0, 32'h0, 1'b1);
        offer(6'b000000, 6'b000000, 16'h0040, 5'd7, 32'h55, 5'd3, 32'h8000_0001);
        step();
        in_valid = 1'b0;
        check_head("sll1", 3'b101, 32'h8000_0001, 32'h0, 1'b0);
        step();
        check("ill.issue_count", {16'd0, issue_count}, 32'd10);

        // Flush of a full buffer drops the concurrent push and pop
        out_ready = 1'b0;
        offer(6'b001100, 6'b000000, 16'h00FF, 5'd1, 32'hF0F0, 5'd2, 32'h0);
        step();
        step();
        check("fl.full", {31'd0, in_ready}, 32'd0);
        flush = 1'b1; out_ready = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("fl.out_valid", {31'd0, out_valid}, 32'd0);
        check("fl.in_ready", {31'd0, in_ready}, 32'd1);
        check("fl.issue_count", {16'd0, issue_count}, 32'd10);
        step();
        check("fl.still_empty", {31'd0, out_valid}, 32'd0);

        // Stream until issue_count reaches 0xFFFF, then one more pop wraps it
        offer(6'b000000, 6'b100000, 16'd0, 5'd1, 32'h1, 5'd2, 32'h1);
        steps = 0;
        while (issue_count != 16'hFFFF && steps < 70000) begin
            step();
            steps++;
        end
        check("wrap.reached_ffff", {16'd0, issue_count}, 32'h0000_FFFF);
        in_valid = 1'b0;
        step();
        check("wrap.zero", {16'd0, issue_count}, 32'd0);

        // Asynchronous reset mid-operation
        out_ready = 1'b0;
        offer(6'b001000, 6'b000000, 16'h0001, 5'd1, 32'h7, 5'd2, 32'h0);
        step();
        in_valid = 1'b0;
        check("arst.pre_valid", {31'd0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst.out_valid", {31'd0, out_valid}, 32'd0);
        check("arst.in_ready", {31'd0, in_ready}, 32'd0);
        check("arst.out_a", out_a, 32'd0);
        check("arst.issue_count", {16'd0, issue_count}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
